// File: rtl/bh_cmd_sequencer.sv
// Host-bus command sequencer: queues commands written over an async 8-bit bus and
// hands them one at a time to a payload. Optional WAIT_DONE timeout: BH_CMD_TIMEOUT_EN.
module bh_cmd_sequencer #(
  parameter logic [15:0] ID_MAJOR    = 16'h0000,
  parameter logic [7:0]  ID_MINOR    = 8'h00,
  parameter int          CMD_W       = 4,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          OSC_MHZ     = 24,
  parameter int          TIMEOUT_CYC = 24000
) (
  input  logic             osc,
  input  logic             rst_n,
  input  logic [7:0]       bus_data_in,
  output logic [7:0]       bus_data_out,
  output logic             bus_data_oe,
  input  logic             bus_ale,
  input  logic             bus_write,
  input  logic             bus_read,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_nr,
  output logic [7:0]       cmd_arg,
  input  logic             cmd_done,
  input  logic [7:0]       cmd_result,
  input  logic [11:0]      cmd_delay_us
);

`ifdef BH_CMD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int EW    = CMD_W + 8;
  localparam int DLY_W = $clog2(OSC_MHZ * 4095);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, DELAY} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ale_s_q, ale_s_d, wr_s_q, wr_s_d, rd_s_q, rd_s_d;
  logic [7:0]         addr_q, addr_d, arg_q, arg_d, result_q, result_d;
  logic [7:0]         dout_q, dout_d;
  logic               rd_pend_q, rd_pend_d, oe_q, oe_d;
  logic               ovf_q, ovf_d, tmo_flag_q, tmo_flag_d;
  logic [EW-1:0]      fifo_q [FIFO_DEPTH];
  logic [EW-1:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CMD_W-1:0]   cmd_nr_q, cmd_nr_d;
  logic [7:0]         cmd_arg_q, cmd_arg_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic               ale_fall, wr_rise, rd_fall, rd_hi;
  logic               full, empty, push, push_ok, pop;
  logic [7:0]         status;

  // Stage [0] and [1] form the synchroniser; [2] is the previous synced value.
  assign ale_s_d  = {ale_s_q[1:0], bus_ale};
  assign wr_s_d   = {wr_s_q[1:0], bus_write};
  assign rd_s_d   = {rd_s_q[1:0], bus_read};
  assign ale_fall = ~ale_s_q[1] & ale_s_q[2];
  assign wr_rise  = wr_s_q[1] & ~wr_s_q[2];
  assign rd_fall  = ~rd_s_q[1] & rd_s_q[2];
  assign rd_hi    = rd_s_q[1];

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign status = {4'(count_q), tmo_flag_q, ovf_q, full,
                   (state_q != IDLE) || !empty};

  assign cmd_valid    = (state_q == WAIT_DONE);
  assign cmd_nr       = cmd_nr_q;
  assign cmd_arg      = cmd_arg_q;
  assign bus_data_out = dout_q;
  // Drop the drive enable combinationally as soon as the synced strobe returns high.
  assign bus_data_oe  = oe_q & ~rd_hi & addr_q[4];

  always_comb begin
    addr_d     = addr_q;
    arg_d      = arg_q;
    result_d   = result_q;
    dout_d     = dout_q;
    rd_pend_d  = 1'b0;
    oe_d       = oe_q;
    ovf_d      = ovf_q;
    tmo_flag_d = tmo_flag_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    cmd_nr_d   = cmd_nr_q;
    cmd_arg_d  = cmd_arg_q;
    dly_d      = dly_q;
    tmo_cnt_d  = tmo_cnt_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (ale_fall) addr_d = bus_data_in;

    if (wr_rise) begin
      case (addr_q)
        8'h10:   arg_d = bus_data_in;
        8'h11:   push  = 1'b1;
        8'h12: begin
          ovf_d      = 1'b0;
          tmo_flag_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (rd_fall) begin
      case (addr_q)
        8'h10:   dout_d = status;
        8'h11:   dout_d = result_q;
        8'hFD:   dout_d = ID_MAJOR[7:0];
        8'hFE:   dout_d = ID_MAJOR[15:8];
        8'hFF:   dout_d = ID_MINOR;
        default: dout_d = 8'h00;
      endcase
      rd_pend_d = addr_q[4];
    end

    if (rd_hi)          oe_d = 1'b0;
    else if (rd_pend_q) oe_d = 1'b1;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          cmd_nr_d  = fifo_q[rd_ptr_q][EW-1:8];
          cmd_arg_d = fifo_q[rd_ptr_q][7:0];
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd_done) begin
          result_d = cmd_result;
          if (cmd_delay_us != 12'd0) begin
            dly_d   = DLY_W'(OSC_MHZ) * DLY_W'(cmd_delay_us) - DLY_W'(1);
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end else if (TMO_EN && tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          result_d   = 8'hEE;
          tmo_flag_d = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      DELAY: begin
        if (dly_q == '0) state_d = IDLE;
        else             dly_d   = dly_q - DLY_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // A pop frees no slot for a push in the same cycle: full means drop.
    push_ok = push & ~full;
    if (push & full) ovf_d = 1'b1;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = {bus_data_in[CMD_W-1:0], arg_q};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ale_s_q    <= 3'b000;
      wr_s_q     <= 3'b000;
      rd_s_q     <= 3'b111;
      addr_q     <= 8'h00;
      arg_q      <= 8'h00;
      result_q   <= 8'h00;
      dout_q     <= 8'h00;
      rd_pend_q  <= 1'b0;
      oe_q       <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_nr_q   <= '0;
      cmd_arg_q  <= 8'h00;
      dly_q      <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ale_s_q    <= ale_s_d;
      wr_s_q     <= wr_s_d;
      rd_s_q     <= rd_s_d;
      addr_q     <= addr_d;
      arg_q      <= arg_d;
      result_q   <= result_d;
      dout_q     <= dout_d;
      rd_pend_q  <= rd_pend_d;
      oe_q       <= oe_d;
      ovf_q      <= ovf_d;
      tmo_flag_q <= tmo_flag_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_nr_q   <= cmd_nr_d;
      cmd_arg_q  <= cmd_arg_d;
      dly_q      <= dly_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_bh_cmd_sequencer.sv
// Directed bench for bh_cmd_sequencer: register-read table plus hand-built
// sequences for command latency, delay length, overflow, reset and timeout.
module tb_bh_cmd_sequencer;

  logic        osc = 1'b0;
  logic        rst_n;
  logic [7:0]  bus_data_in, bus_data_out;
  logic        bus_data_oe, bus_ale, bus_write, bus_read;
  logic        cmd_valid;
  logic [3:0]  cmd_nr;
  logic [7:0]  cmd_arg;
  logic        cmd_done;
  logic [7:0]  cmd_result;
  logic [11:0] cmd_delay_us;

  int passed = 0;
  int total  = 0;

  always #5 osc = ~osc;

  bh_cmd_sequencer #(
    .ID_MAJOR(16'h1234), .ID_MINOR(8'h05), .CMD_W(4), .FIFO_DEPTH(4),
    .OSC_MHZ(24), .TIMEOUT_CYC(100)
  ) dut (
    .osc(osc), .rst_n(rst_n),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_ale(bus_ale), .bus_write(bus_write), .bus_read(bus_read),
    .cmd_valid(cmd_valid), .cmd_nr(cmd_nr), .cmd_arg(cmd_arg),
    .cmd_done(cmd_done), .cmd_result(cmd_result), .cmd_delay_us(cmd_delay_us)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp_data;
    bit         exp_oe;
  } rd_vec_t;

  rd_vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic set_addr(input logic [7:0] a);
    @(negedge osc);
    bus_data_in = a;
    bus_ale = 1'b1;
    repeat (4) @(negedge osc);
    bus_ale = 1'b0;
    repeat (4) @(negedge osc);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    set_addr(a);
    bus_data_in = d;
    bus_write = 1'b1;
    repeat (4) @(negedge osc);
    bus_write = 1'b0;
    repeat (4) @(negedge osc);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output bit seen);
    set_addr(a);
    bus_read = 1'b0;
    seen = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge osc);
      if (bus_data_oe && !seen) begin
        seen = 1'b1;
        d = bus_data_out;
      end
    end
    bus_read = 1'b1;
    repeat (4) @(negedge osc);
  endtask

  task automatic rd_check(input string nm, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bit seen;
    bus_rd(a, d, seen);
    check({nm, "_oe"}, 32'(seen), 32'd1);
    check(nm, 32'(d), 32'(exp));
  endtask

  task automatic done_pulse(input logic [7:0] res, input logic [11:0] dly);
    @(negedge osc);
    cmd_done = 1'b1;
    cmd_result = res;
    cmd_delay_us = dly;
    @(posedge osc); #1;
    cmd_done = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bit seen;
    int n;

    vecs[0] = '{8'hFD, 8'h34, 1'b1};
    vecs[1] = '{8'hFE, 8'h12, 1'b1};
    vecs[2] = '{8'hFF, 8'h05, 1'b1};
    vecs[3] = '{8'h10, 8'h00, 1'b1};
    vecs[4] = '{8'h11, 8'h00, 1'b1};
    vecs[5] = '{8'h13, 8'h00, 1'b1};
    vecs[6] = '{8'h0F, 8'h00, 1'b0};
    vecs[7] = '{8'h20, 8'h00, 1'b0};

    rst_n = 1'b0;
    bus_data_in = 8'h00; bus_ale = 1'b0; bus_write = 1'b0; bus_read = 1'b1;
    cmd_done = 1'b0; cmd_result = 8'h00; cmd_delay_us = 12'd0;
    repeat (3) @(negedge osc);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_oe", 32'(bus_data_oe), 32'd0);
    check("rst_dout", 32'(bus_data_out), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge osc);

    for (int i = 0; i < 8; i++) begin
      bus_rd(vecs[i].addr, d, seen);
      check($sformatf("rd_oe_%02h", vecs[i].addr), 32'(seen), 32'(vecs[i].exp_oe));
      if (vecs[i].exp_oe)
        check($sformatf("rd_data_%02h", vecs[i].addr), 32'(d), 32'(vecs[i].exp_data));
    end

    // First command: exact two-cycle latency after the commit cycle.
    bus_wr(8'h10, 8'h5A);
    set_addr(8'h11);
    bus_data_in = 8'h03;
    bus_write = 1'b1;
    repeat (3) @(posedge osc);
    #1 check("valid_before", 32'(cmd_valid), 32'd0);
    @(posedge osc);
    #1 check("valid_rise", 32'(cmd_valid), 32'd1);
    check("cmd_nr_3", 32'(cmd_nr), 32'd3);
    check("cmd_arg_5a", 32'(cmd_arg), 32'h5A);
    @(negedge osc);
    bus_write = 1'b0;
    repeat (4) @(negedge osc);

    // Queue a second command; the presented one must not change.
    bus_wr(8'h10, 8'hC3);
    bus_wr(8'h11, 8'h07);
    check("cmd_nr_stable", 32'(cmd_nr), 32'd3);
    check("cmd_arg_stable", 32'(cmd_arg), 32'h5A);

    // 2 us at 24 MHz = 48 DELAY cycles, then one IDLE cycle pops the next.
    done_pulse(8'h81, 12'd2);
    check("valid_after_done", 32'(cmd_valid), 32'd0);
    n = 0;
    while (!cmd_valid && n < 200) begin
      @(posedge osc); #1;
      n++;
    end
    check("delay_cycles", 32'(n), 32'd49);
    check("cmd_nr_7", 32'(cmd_nr), 32'd7);
    check("cmd_arg_c3", 32'(cmd_arg), 32'hC3);
    rd_check("result_81", 8'h11, 8'h81);

    done_pulse(8'h22, 12'd0);
    check("valid_done_nodelay", 32'(cmd_valid), 32'd0);
    done_pulse(8'h99, 12'd0);
    rd_check("done_ignored", 8'h11, 8'h22);
    rd_check("status_idle", 8'h10, 8'h00);

    // Stalled payload: 6 pushes -> 1 active, 4 queued, 1 dropped.
    for (int i = 1; i <= 6; i++) begin
      bus_wr(8'h10, 8'(8'h10 + i));
      bus_wr(8'h11, 8'(i));
    end
    rd_check("status_ovf", 8'h10, 8'h47);
    bus_wr(8'h12, 8'h00);
    rd_check("status_clr", 8'h10, 8'h43);
    done_pulse(8'h00, 12'd0);
    repeat (2) @(posedge osc);
    #1 check("fifo_order_nr", 32'(cmd_nr), 32'd2);
    check("fifo_order_arg", 32'(cmd_arg), 32'h12);
    rd_check("status_cnt3", 8'h10, 8'h31);

    // Reset mid-command: outputs clear without waiting for a clock.
    @(negedge osc);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_valid", 32'(cmd_valid), 32'd0);
    repeat (2) @(negedge osc);
    rst_n = 1'b1;
    rd_check("status_after_rst", 8'h10, 8'h00);
    rd_check("result_after_rst", 8'h11, 8'h00);

    // Stalled command: timeout behaviour depends on the build.
    set_addr(8'h11);
    bus_data_in = 8'h05;
    bus_write = 1'b1;
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(posedge osc); #1;
      n++;
    end
    check("tmo_cmd_start", 32'(cmd_valid), 32'd1);
`ifdef BH_CMD_TIMEOUT_EN
    repeat (99) @(posedge osc);
    #1 check("tmo_valid_99", 32'(cmd_valid), 32'd1);
    @(posedge osc);
    #1 check("tmo_valid_100", 32'(cmd_valid), 32'd0);
    bus_write = 1'b0;
    rd_check("tmo_result", 8'h11, 8'hEE);
    rd_check("tmo_status", 8'h10, 8'h08);
`else
    repeat (150) @(posedge osc);
    #1 check("notmo_valid", 32'(cmd_valid), 32'd1);
    bus_write = 1'b0;
    rd_check("notmo_status", 8'h10, 8'h01);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bh_cmd_sequencer.md
BH_CMD_SEQUENCER -- requirements
Module: bh_cmd_sequencer

Interface
REQ-001 The block SHALL have one clock (osc) and an asynchronous, active-low reset (rst_n).
REQ-002 Parameter ID_MAJOR, default 16'h0000, is the 16-bit runtime ID major.
REQ-003 Parameter ID_MINOR, default 8'h00, is the 8-bit runtime ID minor.
REQ-004 Parameter CMD_W, default 4, is the command number width (1..8).
REQ-005 Parameter FIFO_DEPTH, default 4, is the command queue depth (power of 2, 2..8).
REQ-006 Parameter OSC_MHZ, default 24, is the osc frequency in MHz used for delay scaling.
REQ-007 Parameter TIMEOUT_CYC, default 24000, is the cycles allowed in WAIT_DONE.
REQ-008 Ports (name, direction, width, meaning):
- osc  in  1  clock.
- rst_n  in  1  async reset, active low.
- bus_data_in  in  8  host data bus, input side.
- bus_data_out  out  8  host read data.
- bus_data_oe  out  1  host data bus drive enable.
- bus_ale  in  1  address latch enable (async).
- bus_write  in  1  write strobe (async).
- bus_read  in  1  read strobe, active low (async).
- cmd_valid  out  1  command presented to payload.
- cmd_nr  out  CMD_W  current command number.
- cmd_arg  out  8  current command argument.
- cmd_done  in  1  payload completion pulse.
- cmd_result  in  8  payload result, sampled with cmd_done.
- cmd_delay_us  in  12  post-command delay in us, sampled with cmd_done.

Function
REQ-009 bus_ale, bus_write and bus_read SHALL each pass a 2-flop synchroniser; edges are detected on the synchronised signals.
REQ-010 A falling ale edge SHALL latch bus_data_in into addr; address bit 4 is the "address OK" bit.
REQ-011 A rising write edge SHALL commit bus_data_in as follows:
- 0x10: stage arg.
- 0x11: push {data[CMD_W-1:0], arg} into the FIFO.
- 0x12: clear the sticky flags.
- Any other address: ignored.
REQ-012 A falling read edge SHALL load bus_data_out from the addressed source:
- 0x10: status.
- 0x11: result.
- 0xFD: ID_MAJOR[7:0].
- 0xFE: ID_MAJOR[15:8].
- 0xFF: ID_MINOR.
- Any other address: 0x00.
REQ-013 bus_data_oe SHALL assert one cycle after bus_data_out loads and deassert in the cycle synchronised read goes high; it SHALL never assert when addr[4]=0.
REQ-014 Status SHALL be laid out as: bit0 busy (state≠IDLE or FIFO non-empty), bit1 full, bit2 overflow, bit3 timeout, bits7:4 FIFO count.
REQ-015 A push while the FIFO is full SHALL be dropped and SHALL set the overflow flag; a push when not full is always accepted, including in a same-cycle pop.
REQ-016 The FSM SHALL have states IDLE, WAIT_DONE and DELAY.
REQ-017 IDLE with the FIFO non-empty SHALL pop, load cmd_nr/cmd_arg and enter WAIT_DONE; cmd_valid SHALL rise 2 cycles after the push-commit cycle.
REQ-018 cmd_valid SHALL be high exactly while in WAIT_DONE, and cmd_nr/cmd_arg SHALL be stable throughout.
REQ-019 cmd_done in WAIT_DONE SHALL capture cmd_result into result and exit to DELAY if cmd_delay_us≠0, else to IDLE.
REQ-020 cmd_done outside WAIT_DONE SHALL be ignored.
REQ-021 On DELAY entry the counter SHALL load OSC_MHZ*cmd_delay_us-1 (width ceil(log2(OSC_MHZ*4095))).
REQ-022 DELAY SHALL decrement the counter each cycle and return to IDLE on the cycle after it reads 0.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL saturate at neither bound (full/empty exact).

Reset
REQ-024 While rst_n=0 the block SHALL immediately:
- set cmd_valid=0, bus_data_oe=0, bus_data_out=0x00.
- clear addr, arg, result, FIFO, counters and flags, and all synchronisers to idle level (ale=0, write=0, read=1).
- set state=IDLE.
REQ-025 Reset mid-command SHALL abandon the command without capturing a result.

Configuration
REQ-026 With BH_CMD_TIMEOUT_EN defined, WAIT_DONE SHALL count cycles; on the TIMEOUT_CYC-th cycle without cmd_done it SHALL go to IDLE, set result=0xEE and set the timeout flag.
REQ-027 Without BH_CMD_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely and status bit3 SHALL read 0.

Verification
REQ-028 Write 0x10←0x5A, 0x11←0x3 -> cmd_valid high 2 cycles after commit with cmd_nr=3, cmd_arg=0x5A.
REQ-029 cmd_done with cmd_result=0x81 and cmd_delay_us=2 -> reading 0x11 returns 0x81, cmd_valid stays low, and busy=1 for exactly 48 osc cycles of DELAY before the next pop.
REQ-030 With the payload stalled, issue 6 pushes with FIFO_DEPTH=4 -> one in WAIT_DONE, 4 queued, 1 dropped; status=0x47; a write to 0x12 clears bit2.
REQ-031 Reads of 0xFD/0xFE/0xFF with ID_MAJOR=16'h1234, ID_MINOR=8'h05 -> 0x34, 0x12, 0x05; a read with addr=0x0F -> bus_data_oe never asserts.
REQ-032 Pull rst_n low in WAIT_DONE -> cmd_valid is 0 in the same cycle; after release, status=0x00.
REQ-033 With BH_CMD_TIMEOUT_EN and TIMEOUT_CYC=100 and no cmd_done -> after 100 cycles, result=0xEE and status bit3=1.
